pipe_hazard_ctrl: RTL

Parametrised pipeline hazard controller for the five-stage core: the next generation of the combinational stage controller. It keeps the M/WB→EX operand forwarding and the load-use, redirect and jump handling, and adds three sequential features: a counted multi-cycle EX stall, a variable-latency data-memory wait with a timeout, and saturating performance counters. It sits beside the datapath and drives the PC stall line and the four pipeline-register control fields (NORMAL 2'b00, STALL 2'b01, BUBBLE 2'b10).

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core: M/WB->EX forwarding, load-use,
// redirect/jump flushes, counted multi-cycle EX stall, memory-wait timeout and perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MULTI_LAT   = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ex_rs1_id,
  input  logic [REG_AW-1:0] ex_rs2_id,
  input  logic              ex_uses_rs2,
  input  logic              ex_is_multi,
  input  logic              ex_redirect,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] m_rd_id,
  input  logic [REG_AW-1:0] wb_rd_id,
  input  logic              m_wr_reg,
  input  logic              wb_wr_reg,
  input  logic              m_is_load,
  input  logic              m_mem_req,
  input  logic              dmem_ready,
  output logic [1:0]        rs1_fwd,
  output logic [1:0]        rs2_fwd,
  output logic              pc_stall,
  output logic [1:0]        if_id_ctr,
  output logic [1:0]        id_ex_ctr,
  output logic [1:0]        ex_m_ctr,
  output logic [1:0]        m_wb_ctr,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] CTR_NORMAL = 2'b00;
  localparam logic [1:0] CTR_STALL  = 2'b01;
  localparam logic [1:0] CTR_BUBBLE = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam int         WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [3:0] MCNT_LOAD  = 4'(MULTI_LAT - 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MULTI} state_e;

  state_e            state;
  logic [3:0]        mcnt;
  logic              multi_done;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_wait;
  logic load_use;
  logic multi_hold;
  logic redirect_act;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic [REG_AW-1:0] wb_rd,
    input logic              m_wr,
    input logic              m_load,
    input logic              wb_wr
  );
    if (m_wr && !m_load && (m_rd == rs) && (rs != '0)) return FWD_M;
    if (wb_wr && (wb_rd == rs) && (rs != '0))          return FWD_WB;
    return FWD_RF;
  endfunction

  assign rs1_fwd = fwd_sel(ex_rs1_id, m_rd_id, wb_rd_id, m_wr_reg, m_is_load, wb_wr_reg);
  assign rs2_fwd = fwd_sel(ex_rs2_id, m_rd_id, wb_rd_id, m_wr_reg, m_is_load, wb_wr_reg);

  assign mem_wait   = m_mem_req && !dmem_ready;
  assign load_use   = m_is_load && m_wr_reg && (m_rd_id != '0) &&
                      ((m_rd_id == ex_rs1_id) || (ex_uses_rs2 && (m_rd_id == ex_rs2_id)));
  assign multi_hold = (state == MULTI) || (ex_is_multi && !multi_done);

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_ctr    = CTR_NORMAL;
    id_ex_ctr    = CTR_NORMAL;
    ex_m_ctr     = CTR_NORMAL;
    m_wb_ctr     = CTR_NORMAL;
    redirect_act = 1'b0;
    if (!rst_n) begin
      pc_stall  = 1'b1;
      if_id_ctr = CTR_BUBBLE;
      id_ex_ctr = CTR_BUBBLE;
      ex_m_ctr  = CTR_BUBBLE;
      m_wb_ctr  = CTR_BUBBLE;
    end else if (mem_wait) begin
      pc_stall  = 1'b1;
      if_id_ctr = CTR_STALL;
      id_ex_ctr = CTR_STALL;
      ex_m_ctr  = CTR_STALL;
      m_wb_ctr  = CTR_BUBBLE;
    end else if (load_use || multi_hold) begin
      pc_stall  = 1'b1;
      if_id_ctr = CTR_STALL;
      id_ex_ctr = CTR_STALL;
      ex_m_ctr  = CTR_BUBBLE;
    end else if (ex_redirect) begin
      if_id_ctr    = CTR_BUBBLE;
      id_ex_ctr    = CTR_BUBBLE;
      redirect_act = 1'b1;
    end else if (id_jump) begin
      if_id_ctr = CTR_BUBBLE;
    end
  end

  // The entry cycle in RUN is the first stall cycle, so MULTI is left when mcnt is about
  // to expire; this yields exactly MULTI_LAT-1 stall cycles. MULTI_LAT==2 never enters MULTI.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      mcnt       <= '0;
      multi_done <= 1'b0;
    end else if (!mem_wait) begin
      case (state)
        RUN: begin
          if (!load_use && ex_is_multi && !multi_done) begin
            if (MULTI_LAT > 2) begin
              state <= MULTI;
              mcnt  <= MCNT_LOAD;
            end else begin
              multi_done <= 1'b1;
            end
          end else if (id_ex_ctr != CTR_STALL) begin
            multi_done <= 1'b0;
          end
        end
        MULTI: begin
          if (mcnt <= 4'd1) begin
            state      <= RUN;
            mcnt       <= '0;
            multi_done <= 1'b1;
          end else begin
            mcnt <= mcnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt == WAIT_LAST) mem_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))     stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_act && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
